// File: rtl/vga_board_pkg.sv
// Shared cell encodings, 12-bit colour constants and the per-pixel flag record
// carried down the vga_board_renderer pipeline.
package vga_board_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   localparam logic [11:0] RGB_BLACK  = 12'h000;
   localparam logic [11:0] RGB_WHITE  = 12'hFFF;
   localparam logic [11:0] RGB_RED    = 12'hF00;
   localparam logic [11:0] RGB_GREEN  = 12'h0F0;
   localparam logic [11:0] RGB_YELLOW = 12'hFF0;
   localparam logic [11:0] RGB_GRAY   = 12'h222;

   typedef struct packed {
      logic       en;
      logic       off_board;
      logic [1:0] state;
      logic       sel;
      logic       win;
      logic       border;
      logic       hl;
   } pix_flags_t;

   // True when rel lies within w pixels of either edge of a span of the given size.
   function automatic logic in_band(input logic [9:0] rel, input int unsigned size,
                                    input int unsigned w);
      return (32'(rel) < w) || (32'(rel) >= size - w);
   endfunction

endpackage

// File: rtl/vga_cell_locator.sv
// Stage S1: maps a screen coordinate to a board cell and the offset inside it,
// using a comparator chain against constant cell boundaries.
module vga_cell_locator #(
   parameter int unsigned GRID_N = 3,
   parameter int unsigned CELL_W = 213,
   parameter int unsigned CELL_H = 160
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [9:0]                x,
   input  logic [9:0]                y,
   output logic [$clog2(GRID_N)-1:0] cx,
   output logic [$clog2(GRID_N)-1:0] cy,
   output logic [9:0]                rel_x,
   output logic [9:0]                rel_y,
   output logic                      off_board
);

   localparam int unsigned CXW = $clog2(GRID_N);

   logic [CXW-1:0] cx_d, cy_d;
   logic [9:0]     base_x, base_y;

   // Boundaries c*CELL_W are elaboration constants; only compares touch x and y.
   always_comb begin
      cx_d   = '0;
      cy_d   = '0;
      base_x = '0;
      base_y = '0;
      for (int unsigned c = 1; c < GRID_N; c++) begin
         if (32'(x) >= c * CELL_W) begin
            cx_d   = CXW'(c);
            base_x = 10'(c * CELL_W);
         end
         if (32'(y) >= c * CELL_H) begin
            cy_d   = CXW'(c);
            base_y = 10'(c * CELL_H);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cx        <= '0;
         cy        <= '0;
         rel_x     <= '0;
         rel_y     <= '0;
         off_board <= 1'b0;
      end else begin
         cx        <= cx_d;
         cy        <= cy_d;
         rel_x     <= x - base_x;
         rel_y     <= y - base_y;
         off_board <= (32'(x) >= GRID_N * CELL_W) || (32'(y) >= GRID_N * CELL_H);
      end
   end

endmodule

// File: rtl/vga_board_renderer.sv
// N x N board renderer: frame-latched board updates, win marking, sprite ROM fetch.
// Blinking of highlight and win colouring is built when VGA_BOARD_BLINK_EN is defined.
module vga_board_renderer
   import vga_board_pkg::*;
#(
   parameter int unsigned GRID_N       = 3,
   parameter int unsigned CELL_W       = 213,
   parameter int unsigned CELL_H       = 160,
   parameter int unsigned LINE_W       = 3,
   parameter int unsigned HL_W         = 6,
   parameter int unsigned ROM_LAT      = 1,
   parameter int unsigned ROM_AW       = 17,
   parameter int unsigned P2_OFFSET    = CELL_W * CELL_H,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [9:0]                 x,
   input  logic [9:0]                 y,
   input  logic                       en,
   input  logic                       frame_start,
   input  logic [2*GRID_N*GRID_N-1:0] board,
   input  logic                       board_wr,
   output logic                       board_busy,
   input  logic [GRID_N*GRID_N-1:0]   sel,
   input  logic [GRID_N*GRID_N-1:0]   win_mask,
   output logic [ROM_AW-1:0]          rom_addr,
   input  logic [11:0]                rom_data,
   output logic [3:0]                 red,
   output logic [3:0]                 green,
   output logic [3:0]                 blue
);

   localparam int unsigned NC    = GRID_N * GRID_N;
   localparam int unsigned CXW   = $clog2(GRID_N);
   localparam int unsigned IDX_W = $clog2(NC);

   logic [2*NC-1:0] board_snap, board_pend;
   logic [NC-1:0]   sel_snap, win_snap;
   logic            show_blink;

   logic [CXW-1:0]   s1_cx, s1_cy;
   logic [9:0]       s1_rel_x, s1_rel_y;
   logic             s1_off, s1_en;
   logic [IDX_W-1:0] cell_idx;
   logic [1:0]       cell_raw, cell_state;
   logic             cell_sel, cell_win;
   pix_flags_t       flags_d, out_f;
   pix_flags_t       flags_q [ROM_LAT+1];
   logic [ROM_AW-1:0] rom_addr_d;
   logic [11:0]      rgb_d;

   if (HL_W <= LINE_W || BLINK_FRAMES == 0) begin : g_param_check
      $error("vga_board_renderer: HL_W must exceed LINE_W and BLINK_FRAMES must be nonzero");
   end

   // Coincident write and frame_start also refreshes pending, so a later
   // frame_start without a write cannot revert the snapshot to a stale board.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         board_snap <= '0;
         board_pend <= '0;
         board_busy <= 1'b0;
         sel_snap   <= '0;
         win_snap   <= '0;
      end else if (frame_start) begin
         sel_snap   <= sel;
         win_snap   <= win_mask;
         board_busy <= 1'b0;
         if (board_wr) begin
            board_snap <= board;
            board_pend <= board;
         end else if (board_busy) begin
            board_snap <= board_pend;
         end
      end else if (board_wr) begin
         board_pend <= board;
         board_busy <= 1'b1;
      end
   end

`ifdef VGA_BOARD_BLINK_EN
   localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FC_W-1:0] frame_cnt;
   logic            blink_phase;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_start) begin
         if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end
   assign show_blink = blink_phase;
`else
   assign show_blink = 1'b1;
`endif

   vga_cell_locator #(
      .GRID_N (GRID_N),
      .CELL_W (CELL_W),
      .CELL_H (CELL_H)
   ) u_locator (
      .clk       (clk),
      .reset_n   (reset_n),
      .x         (x),
      .y         (y),
      .cx        (s1_cx),
      .cy        (s1_cy),
      .rel_x     (s1_rel_x),
      .rel_y     (s1_rel_y),
      .off_board (s1_off)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) s1_en <= 1'b0;
      else          s1_en <= en;
   end

   assign cell_idx = IDX_W'(32'(s1_cy) * GRID_N + 32'(s1_cx));

   always_comb begin
      cell_raw = CELL_EMPTY;
      cell_sel = 1'b0;
      cell_win = 1'b0;
      for (int unsigned i = 0; i < NC; i++) begin
         if (cell_idx == IDX_W'(i)) begin
            cell_raw = board_snap[2*i +: 2];
            cell_sel = sel_snap[i];
            cell_win = win_snap[i];
         end
      end
      cell_state = (s1_off || (cell_raw != CELL_P1 && cell_raw != CELL_P2)) ? CELL_EMPTY : cell_raw;

      flags_d.en        = s1_en;
      flags_d.off_board = s1_off;
      flags_d.state     = cell_state;
      flags_d.sel       = cell_sel;
      flags_d.win       = cell_win;
      flags_d.border    = in_band(s1_rel_x, CELL_W, LINE_W) || in_band(s1_rel_y, CELL_H, LINE_W);
      flags_d.hl        = in_band(s1_rel_x, CELL_W, HL_W) || in_band(s1_rel_y, CELL_H, HL_W);

      if (cell_state == CELL_EMPTY) rom_addr_d = '0;
      else rom_addr_d = ROM_AW'(32'(s1_rel_y) * CELL_W + 32'(s1_rel_x)
                                + ((cell_state == CELL_P2) ? P2_OFFSET : 32'd0));
   end

   // flags_q[0] is registered alongside rom_addr; flags_q[ROM_LAT] lines up with rom_data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_addr <= '0;
         for (int unsigned i = 0; i <= ROM_LAT; i++) flags_q[i] <= '0;
      end else begin
         rom_addr   <= rom_addr_d;
         flags_q[0] <= flags_d;
         for (int unsigned i = 1; i <= ROM_LAT; i++) flags_q[i] <= flags_q[i-1];
      end
   end

   assign out_f = flags_q[ROM_LAT];

   always_comb begin
      if (!out_f.en)                                              rgb_d = RGB_BLACK;
      else if (out_f.off_board)                                   rgb_d = RGB_GRAY;
      else if (out_f.state != CELL_EMPTY && rom_data != '0)       rgb_d = (out_f.state == CELL_P1) ? RGB_GREEN : RGB_RED;
      else if (out_f.sel && out_f.hl && show_blink)               rgb_d = RGB_RED;
      else if (out_f.border)                                      rgb_d = RGB_BLACK;
      else if (out_f.win && show_blink)                           rgb_d = RGB_YELLOW;
      else                                                        rgb_d = RGB_WHITE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) {red, green, blue} <= '0;
      else          {red, green, blue} <= rgb_d;
   end

endmodule

// File: doc/vga_board_renderer.md
# vga_board_renderer

Parametrised N×N game-board pixel renderer for the VGA output path of the tic-tac-toe design. It maps each screen coordinate to a board cell, fetches glyph pixels from an external sprite ROM of configurable read latency, and emits a registered, latency-aligned 12-bit RGB stream. It adds three things to the basic renderer: tear-free board updates latched at frame boundaries, win-line marking, and frame-counted blinking. It sits between the VGA timing generator (x, y, en, frame_start) and the DAC pins, with the game FSM as its board source.

## Interface
Parameters:
- GRID_N, 3: cells per row and column (2–8).
- CELL_W, 213: cell width in pixels.
- CELL_H, 160: cell height in pixels.
- LINE_W, 3: cell border thickness.
- HL_W, 6: cursor-highlight thickness; must be greater than LINE_W.
- ROM_LAT, 1: sprite ROM read latency in cycles (1–3).
- ROM_AW, 17: sprite ROM address width.
- P2_OFFSET, CELL_W*CELL_H: base address of the X glyph; the circle glyph is at 0.
- BLINK_FRAMES, 30: frames per blink half-period.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- x  in  10  pixel column.
- y  in  10  pixel row.
- en  in  1  active-video qualifier.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- board  in  2*GRID_N*GRID_N  cell states; cell i occupies bits [2i+1:2i], with i = row*GRID_N + col.
- board_wr  in  1  request to load `board`.
- board_busy  out  1  a loaded board is pending and not yet displayed.
- sel  in  GRID_N*GRID_N  cursor mask.
- win_mask  in  GRID_N*GRID_N  winning-line cells.
- rom_addr  out  ROM_AW  sprite ROM address.
- rom_data  in  12  sprite ROM data; any nonzero value is a glyph pixel.
- red  out  4
- green  out  4
- blue  out  4

## Operation
- Cell states:
  - 00: empty.
  - 01: player 1, circle.
  - 10: player 2, X.
  - 11: treated as empty.
- Board handshake:
  - board_wr copies `board` into the pending register and sets board_busy.
  - At frame_start, pending is copied to the display snapshot and board_busy clears.
  - board_wr while busy overwrites pending; last write wins.
  - board_wr coincident with frame_start loads the snapshot directly from `board`; board_busy stays 0.
- sel and win_mask are sampled into display registers at every frame_start.
- Stage S1 (cell locator, comparator chain, no multipliers on x or y):
  - cx = largest c with c*CELL_W ≤ x; same for cy against CELL_H.
  - rel_x = x − cx*CELL_W, rel_y = y − cy*CELL_H.
  - Pixels with x ≥ GRID_N*CELL_W or y ≥ GRID_N*CELL_H are flagged off-board.
- Stage S2:
  - rom_addr = rel_y*CELL_W + rel_x, plus P2_OFFSET for player-2 cells.
  - rom_addr is 0 for empty or off-board pixels.
  - Address arithmetic is done at ROM_AW bits, truncating.
- Flags (en, off-board, state, selected, win, border, highlight) travel in a delay line of ROM_LAT stages so they align with rom_data.
- Colour priority, highest first:
  - !en: 000.
  - Off-board: 222.
  - Glyph pixel on an occupied cell: player 1 0F0, player 2 F00.
  - Highlight band on a selected cell, when visible: F00.
  - Border band: 000.
  - Win cell, when visible: FF0.
  - Otherwise: FFF.
- Border band: rel_x < LINE_W, rel_x ≥ CELL_W−LINE_W, or the same tests on rel_y against CELL_H. The highlight band uses the same tests with HL_W.
- Frame counter: increments at each frame_start. When it reaches BLINK_FRAMES−1 it wraps to 0 and toggles blink_phase.

## Timing
- Pixel (x, y, en) presented at cycle t appears on red/green/blue at t + ROM_LAT + 3.
- rom_addr is registered and changes at t+2.
- A board loaded at frame_start cycle f affects pixels presented from f+1 onward.
- Reset values:
  - red, green, blue, rom_addr: 0.
  - board_busy: 0.
  - Snapshot, pending, sel and win display registers: 0.
  - Frame counter and blink_phase: 0.
  - All pipeline flags: en=0.
- Deasserting reset_n mid-frame clears the pipeline, so output is black for the next ROM_LAT+3 cycles. No partial board is retained.

## Configuration
- VGA_BOARD_BLINK_EN defined:
  - The highlight is visible only when blink_phase=1.
  - Win cells show FF0 only when blink_phase=1, and FFF otherwise.
- VGA_BOARD_BLINK_EN undefined:
  - The frame counter and blink_phase are not built.
  - Highlight and win colouring are always visible.

## Structure
- Package vga_board_pkg holds:
  - Cell-state encodings (CELL_EMPTY, CELL_P1, CELL_P2).
  - 12-bit colour constants (black, white, red, green, yellow, gray).
- Sub-module vga_cell_locator implements stage S1: x, y in; registered cx, cy, rel_x, rel_y and off_board out. It is parametrised by GRID_N, CELL_W and CELL_H.

## Test plan
- Reset and latency: hold reset_n=0, release, drive en=1 at (300,200) with an empty board → black for ROM_LAT+3 cycles, then FFF.
- Glyph fetch, default parameters: cell 4 = 01, pixel (300,200) → rom_addr = 40*213+87 = 8607 at t+2; with rom_data nonzero, output 0F0 at t+ROM_LAT+3. Repeat with cell 4 = 10 → rom_addr = 34080+8607 = 42687, output F00.
- Frame-latched update: board_wr mid-frame with cell 0 = 01 → board_busy=1 and cell 0 still renders empty until frame_start, then busy=0 and the glyph appears. board_wr coincident with frame_start → busy never rises.
- Borders and off-board: (0,0) → 000; with sel[8]=1, pixel (425+5, 320+2) → F00; pixel (639,479) → 222. Run the same scenario with GRID_N=4, CELL_W=100, CELL_H=100: (405,10) → 222.
- Blink (VGA_BOARD_BLINK_EN defined): win_mask[0]=1, BLINK_FRAMES=2 → cell-0 interior alternates FFF and FF0 every 2 frame_start pulses. With the macro undefined → constant FF0.
- ROM latency sweep: ROM_LAT = 1, 2, 3 against a ROM model of matching latency → output latency tracks ROM_LAT+3 and no glyph pixels are misaligned relative to cell borders.
